// File: rtl/pc_seq_pkg.sv
// Shared definitions for the program-counter sequencer and other front-panel
// timing blocks: FSM state encoding and default divider terminal counts.
package pc_seq_pkg;

    typedef enum logic [1:0] {
        ST_HALT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_SSTEP = 2'd2,
        ST_BRK   = 2'd3
    } pc_state_e;

    // Default cycles-per-advance for the fast and slow panel speeds.
    localparam int PC_DIV_FAST = 2500000;
    localparam int PC_DIV_SLOW = 25000000;

endpackage

// File: rtl/pc_sequencer_tick_divider.sv
// Clock-enable divider: counts 0..T-1 while enabled and raises tc for the
// single cycle in which the count sits at T-1. Clearing, disabling or a
// change of speed returns the count to 0 so every period runs at one rate.
module tick_divider #(
    parameter int DIVW     = 26,
    parameter int DIV_FAST = 2500000,
    parameter int DIV_SLOW = 25000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    input  logic speed,
    output logic tc
);

    localparam logic [DIVW-1:0] TERM_FAST = DIVW'(DIV_FAST - 1);
    localparam logic [DIVW-1:0] TERM_SLOW = DIVW'(DIV_SLOW - 1);

    logic [DIVW-1:0] r_cnt;
    logic            r_speed;
    logic [DIVW-1:0] w_term;
    logic            w_speed_chg;
    logic            w_at_term;

    assign w_term      = speed ? TERM_FAST : TERM_SLOW;
    assign w_speed_chg = (speed != r_speed);
    assign w_at_term   = (r_cnt == w_term);
    assign tc          = en && !clr && !w_speed_chg && w_at_term;

    // Count while enabled; any clear, disable, speed change or terminal resets to 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt   <= '0;
            r_speed <= 1'b0;
        end else begin
            r_speed <= speed;
            if (!en || clr || w_speed_chg || w_at_term)
                r_cnt <= '0;
            else
                r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: run/halt, single step, jump load and address
// breakpoint, advancing the pc on a clock-enable from tick_divider.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int W        = 8,
    parameter int DIV_FAST = PC_DIV_FAST,
    parameter int DIV_SLOW = PC_DIV_SLOW,
    parameter int DIVW     = 26
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         run,
    input  logic         step_req,
    input  logic         speed,
    input  logic [W-1:0] step,
    input  logic         load_req,
    input  logic [W-1:0] load_value,
    input  logic         bp_en,
    input  logic [W-1:0] bp_addr,
    output logic [W-1:0] pc,
    output logic         adv,
    output logic [1:0]   state,
    output logic         halted
);

    pc_state_e    r_state;
    logic [W-1:0] r_pc;
    logic         r_adv;
    logic [W-1:0] w_pc_next;
    logic         w_div_en;
    logic         w_tc;

    assign w_pc_next = r_pc + step;
    // Divider only runs while we are in RUN and run is still held; dropping
    // run therefore clears it in the same cycle the FSM returns to HALT.
    assign w_div_en  = (r_state == ST_RUN) && run;

    tick_divider #(
        .DIVW     (DIVW),
        .DIV_FAST (DIV_FAST),
        .DIV_SLOW (DIV_SLOW)
    ) u_div (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (w_div_en),
        .clr   (load_req),
        .speed (speed),
        .tc    (w_tc)
    );

    // FSM and pc register; a load overrides any coinciding advance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_HALT;
            r_pc    <= '0;
            r_adv   <= 1'b0;
        end else begin
            r_adv <= 1'b0;
            if (load_req) begin
                r_pc <= load_value;
                if (r_state == ST_SSTEP)
                    r_state <= ST_HALT;
            end else begin
                case (r_state)
                    ST_HALT: begin
                        if (run)
                            r_state <= ST_RUN;
                        else if (step_req)
                            r_state <= ST_SSTEP;
                    end
                    ST_RUN: begin
                        if (!run) begin
                            r_state <= ST_HALT;
                        end else if (w_tc) begin
                            r_pc  <= w_pc_next;
                            r_adv <= 1'b1;
                            if (bp_en && (w_pc_next == bp_addr))
                                r_state <= ST_BRK;
                        end
                    end
                    ST_SSTEP: begin
                        r_pc    <= w_pc_next;
                        r_adv   <= 1'b1;
                        r_state <= ST_HALT;
                    end
                    ST_BRK: begin
                        if (!run)
                            r_state <= ST_HALT;
                    end
                    default: r_state <= ST_HALT;
                endcase
            end
        end
    end

    assign pc     = r_pc;
    assign adv    = r_adv;
    assign state  = r_state;
    assign halted = (r_state == ST_HALT) || (r_state == ST_BRK);

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Controller that sequences the model computer's program counter.
- Replaces the derived divided clock with a single-clock clock-enable divider.
- Adds run/halt, single-step, synchronous load (jump) and an address breakpoint.
- Sits between the front-panel/debug controls and the instruction-fetch path; pc feeds memory address, adv strobes fetch.

Parameters:
- W, 8, program counter and step width
- DIV_FAST, 2500000, divider terminal count when speed=1 (cycles per advance)
- DIV_SLOW, 25000000, divider terminal count when speed=0
- DIVW, 26, divider counter width; must hold DIV_SLOW-1

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- run  in  1  level; 1 requests free-running execution
- step_req  in  1  one-cycle pulse; request a single advance while halted
- speed  in  1  1 selects DIV_FAST, 0 selects DIV_SLOW
- step  in  W  increment added per advance
- load_req  in  1  one-cycle pulse; load pc from load_value
- load_value  in  W  jump target
- bp_en  in  1  breakpoint enable
- bp_addr  in  W  breakpoint address
- pc  out  W  program counter, registered
- adv  out  1  one-cycle pulse, registered, high in the cycle after pc changed by an advance
- state  out  2  FSM state encoding
- halted  out  1  1 when state is HALT or BRK

Behaviour:
- Reset (rst_n=0, async): pc=0, state=HALT, adv=0, divider=0, halted=1.
- States: HALT=0, RUN=1, SSTEP=2, BRK=3.
- HALT: run=1 -> RUN (takes priority over step_req); else step_req=1 -> SSTEP; otherwise stay.
- RUN: divider counts 0..T-1, where T = speed ? DIV_FAST : DIV_SLOW.
  - At count T-1: pc <= pc+step mod 2^W, divider <= 0, adv pulses.
  - First advance occurs T cycles after entering RUN.
  - run=0 -> HALT next cycle; divider cleared; no advance in that cycle.
  - Breakpoint: if bp_en=1 and the advanced pc equals bp_addr, the advance completes and state -> BRK in the same edge.
- SSTEP: lasts exactly one cycle. pc <= pc+step, adv pulses, state -> HALT. The breakpoint is not checked.
- BRK: pc frozen, divider held at 0. Exits to HALT only once run=0; run staying 1 keeps BRK.
- Speed change while RUN: divider resets to 0 on any change of speed (registered compare), so each period is entirely at one rate.
- load_req, any state:
  - pc <= load_value, divider <= 0, no adv pulse.
  - Overrides a coinciding advance; that advance is dropped, not deferred.
  - SSTEP + load_req -> HALT with the loaded pc.
  - RUN/HALT/BRK keep their state.
  - Breakpoint is not checked against loaded values.
- step=0: advance still pulses adv; pc unchanged; breakpoint is evaluated (pc==bp_addr triggers BRK).
- Wrap: pc arithmetic is modulo 2^W, e.g. 0xFE+0x03=0x01.
- step_req outside HALT is ignored. Simultaneous run and step_req in HALT -> RUN.
- halted is combinational from the state register; all other outputs are registered.
- Reset mid-RUN returns immediately to the reset values; nothing is retained.

Decomposition:
- Shared package pc_seq_pkg: state enum (HALT, RUN, SSTEP, BRK) and the 2-bit encoding; default divider constants DIV_FAST/DIV_SLOW, also usable by other panel timing blocks.
- One sub-module: tick_divider (counter, terminal compare, speed-change clear, enable and clear inputs, one-cycle tc output).
- FSM and pc register live in pc_sequencer.

Test Plan (DIV_FAST=3, DIV_SLOW=6 overridden):
- Reset, then run=1, speed=1, step=1 -> adv at cycles 3,6,9 after entering RUN; pc=1,2,3.
- HALT, step=2, step_req pulse -> one adv; pc 0->2; state back to HALT; further 10 cycles with no pc change.
- RUN, step=1, bp_en=1, bp_addr=4 -> pc stops at 4, state=BRK, halted=1 with run still 1; drop run -> HALT.
- RUN, load_req with value 0x80 in the cycle the divider hits terminal -> pc=0x80, no adv; next adv 3 cycles later gives 0x81.
- pc loaded 0xFE, step=3, step_req -> pc=0x01; then speed toggled mid-period in RUN -> next adv exactly 6 cycles after the toggle.
- rst_n pulled low asynchronously mid-RUN (between edges) -> pc=0, state=HALT, adv=0 immediately, without waiting for clk.
